// File: rtl/wave_gen_pkg.sv
// Shared constants for the phased square-wave generator: reset-time
// configuration and the default per-channel phase rule.
package wave_gen_pkg;

   // Configuration loaded by reset.
   localparam int DEF_PERIOD = 4;
   localparam int DEF_HIGH   = 2;

   // Reset-time phase for channel ch: channels step through 0..3.
   function automatic int default_phase(input int ch);
      return ch & 3;
   endfunction

endpackage

// File: rtl/wave_phase_cmp.sv
// One channel's phase comparator.
// Works out where the shared counter sits inside this channel's shifted
// period, then decides whether the channel is in its high window.
// Math is one bit wider than the fields, so cnt + period cannot overflow
// even at period = 2^CNT_W-1.
module wave_phase_cmp #(
   parameter int CNT_W = 8
) (
   input  logic [CNT_W-1:0] cnt,
   input  logic [CNT_W-1:0] period,
   input  logic [CNT_W-1:0] high,
   input  logic [CNT_W-1:0] phase,
   output logic             hit
);

   logic [CNT_W:0] cnt_x;
   logic [CNT_W:0] per_x;
   logic [CNT_W:0] ph_x;
   logic [CNT_W:0] off;

   // Phase-shifted position within the period and the high-window test.
   always_comb begin
      cnt_x = {1'b0, cnt};
      per_x = {1'b0, period};
      ph_x  = {1'b0, phase};
      off   = '0;
      if (cnt_x >= ph_x) begin
         off = cnt_x - ph_x;
      end else begin
         off = cnt_x + per_x - ph_x;
      end
      // A phase outside the period silences the channel.
      hit = (ph_x < per_x) && (off < {1'b0, high});
   end

endmodule

// File: rtl/phased_wave_gen.sv
// Multi-channel square-wave generator.
// A shared period counter drives NUM_CH phase comparators. All channels share
// one period and high time; each channel has its own phase offset. New
// settings are accepted into a one-entry shadow and become active either at
// the end of a period or on the first disabled clock, so a running waveform
// always completes its current period before it changes.
module phased_wave_gen
   import wave_gen_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int CNT_W  = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    en,
   input  logic                    cfg_valid,
   output logic                    cfg_ready,
   input  logic [CNT_W-1:0]        cfg_period,
   input  logic [CNT_W-1:0]        cfg_high,
   input  logic [NUM_CH*CNT_W-1:0] cfg_phase,
   output logic [NUM_CH-1:0]       out,
   output logic                    wrap
);

   // Active configuration.
   logic [CNT_W-1:0]        act_period;
   logic [CNT_W-1:0]        act_high;
   logic [NUM_CH*CNT_W-1:0] act_phase;

   // Pending shadow configuration.
   logic                    pending;
   logic [CNT_W-1:0]        pend_period;
   logic [CNT_W-1:0]        pend_high;
   logic [NUM_CH*CNT_W-1:0] pend_phase;

   logic [CNT_W-1:0]        cnt;
   logic [CNT_W:0]          cnt_inc;
   logic                    run;
   logic                    at_end;
   logic                    apply;
   logic                    cfg_fire;
   logic [NUM_CH-1:0]       hit;

   // The counter only moves when enabled with a non-idle period. The end test
   // uses the widened increment so period = 2^CNT_W-1 wraps correctly.
   always_comb begin
      cnt_inc  = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
      run      = en && (act_period != '0);
      at_end   = run && (cnt_inc >= {1'b0, act_period});
      // The shadow applies on a period wrap, or straight away once disabled.
      apply    = pending && (!en || at_end);
      cfg_ready = !pending;
      cfg_fire  = cfg_valid && !pending;
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      wave_phase_cmp #(
         .CNT_W (CNT_W)
      ) u_cmp (
         .cnt    (cnt),
         .period (act_period),
         .high   (act_high),
         .phase  (act_phase[g*CNT_W +: CNT_W]),
         .hit    (hit[g])
      );
   end

   // Counter, active/shadow configuration and registered outputs.
   // Reset wins over both the handshake and the enable.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt        <= '0;
         out        <= '0;
         wrap       <= 1'b0;
         pending    <= 1'b0;
         act_period <= CNT_W'(DEF_PERIOD);
         act_high   <= CNT_W'(DEF_HIGH);
         for (int i = 0; i < NUM_CH; i++) begin
            act_phase[i*CNT_W +: CNT_W] <= CNT_W'(default_phase(i));
         end
      end else begin
         // Outputs reflect the counter value present before this edge.
         out  <= en ? hit : '0;
         wrap <= at_end;

         if (apply) begin
            act_period <= pend_period;
            act_high   <= pend_high;
            act_phase  <= pend_phase;
            cnt        <= '0;
         end else if (run) begin
            cnt <= at_end ? '0 : cnt_inc[CNT_W-1:0];
         end else if (en) begin
            // Enabled with an idle period: keep the counter parked at zero.
            cnt <= '0;
         end

         // A transfer needs an empty shadow and an apply needs a full one,
         // so the two never coincide.
         if (cfg_fire) begin
            pending <= 1'b1;
         end else if (apply) begin
            pending <= 1'b0;
         end
      end
   end

   // Shadow data capture; only meaningful while pending is set.
   always_ff @(posedge clk) begin
      if (cfg_fire) begin
         pend_period <= cfg_period;
         pend_high   <= cfg_high;
         pend_phase  <= cfg_phase;
      end
   end

endmodule

// File: doc/phased_wave_gen.md
PHASED_WAVE_GEN -- requirements
Module: phased_wave_gen

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of output channels, legal range 1..16.
REQ-002 SHALL have parameter CNT_W, default 8: width of the counter, period, high-time and phase fields.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic rising-edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port en, input, 1 bit: run enable for the period counter.
REQ-006 SHALL have port cfg_valid, input, 1 bit: configuration offer.
REQ-007 SHALL have port cfg_ready, output, 1 bit: high when no configuration is pending.
REQ-008 SHALL have port cfg_period, input, CNT_W bits: period in clocks; 0 means idle.
REQ-009 SHALL have port cfg_high, input, CNT_W bits: high time in clocks, common to all channels.
REQ-010 SHALL have port cfg_phase, input, NUM_CH*CNT_W bits: per-channel phase offset; channel i in bits [i*CNT_W +: CNT_W].
REQ-011 SHALL have port out, output, NUM_CH bits: registered square-wave outputs.
REQ-012 SHALL have port wrap, output, 1 bit: one-cycle pulse registered on counter wrap.

Function
REQ-013 SHALL hold active config (P, H, PH[i]) plus a one-entry pending shadow.
REQ-014 Config handshake: transfer when cfg_valid && cfg_ready; data goes to the shadow and sets pending; cfg_ready = !pending.
REQ-015 With en=1 and P>0: cnt advances 0..P-1, then goes to 0; wrap is registered high in the cycle after cnt==P-1 advances.
REQ-016 Pending config SHALL apply at the wrap edge, or at the first edge with en=0. Applying it clears pending and forces cnt to 0.
REQ-017 A config accepted on the same edge as a wrap SHALL NOT apply on that wrap; it waits for the next one.
REQ-018 Per channel: off = cnt-PH[i] if cnt>=PH[i], else cnt+P-PH[i]; next out[i] = (PH[i]<P) && (off<H).
REQ-019 out SHALL be registered from the current cnt, so out lags cnt by exactly one clock.
REQ-020 Boundaries: H=0 gives constant 0; H>=P gives constant 1; PH[i]>=P forces out[i]=0.
REQ-021 Arithmetic SHALL be CNT_W+1 bits internally, with no overflow at P=2^CNT_W-1.
REQ-022 With en=0: cnt holds its value, out is registered to all 0, and wrap=0.
REQ-023 On re-enable, cnt SHALL resume from the held value.
REQ-024 P=0: cnt is held at 0, out=0, and wrap never pulses.

Reset
REQ-025 On reset: cnt=0, out=0, wrap=0, pending=0, cfg_ready=1.
REQ-026 On reset the active config SHALL be P=4, H=2, PH[i]=i mod 4.
REQ-027 Reset mid-operation SHALL discard any pending config; reset takes priority over config transfer and en.

Structure
REQ-028 Package wave_gen_pkg SHALL hold DEF_PERIOD=4, DEF_HIGH=2 and the default-phase function.
REQ-029 Sub-module wave_phase_cmp SHALL perform the per-channel offset and compare; it is instantiated NUM_CH times in a generate loop.
REQ-030 Target size is 120-400 lines of RTL; no multipliers or dividers.

Verification
REQ-031 Scenario 1, defaults: reset, then en=1, NUM_CH=2 -> out[0] = 1,1,0,0 repeating; out[1] = 0,1,1,0 repeating, both lagged one clock from cnt; wrap every 4th clock.
REQ-032 Scenario 2, config applied at wrap: at cnt=1, offer P=5, H=1, PH={0,3} -> cfg_ready=0 until wrap; then out[0] high on cnt=0 only and out[1] high on cnt=3 only; cfg_ready=1 the cycle after apply.
REQ-033 Scenario 3, H and PH boundaries: P=6 with H=6 -> both out constant 1. H=0 -> both out constant 0. H=3 with PH[1]=7 -> out[1] constant 0.
REQ-034 Scenario 4, disable mid-period: at cnt=2, en=0 for 3 clocks -> cnt stays 2 and out=0 from the next clock. Re-enable -> cnt continues 3,0,1...
REQ-035 Scenario 5, pending config on disable: with a config pending, drop en -> config applies on the first en=0 edge and cnt=0; P=0 -> out=0 and no wrap for 20 clocks.
REQ-036 Scenario 6, reset mid-operation: reset with a config pending -> next cycle pending=0, cfg_ready=1, and the REQ-031 pattern resumes.
